// File: rtl/image_write_pkg.sv
`default_nettype none
// ============================================================================
// image_write_pkg : register map and FSM encoding for the image write path
// Rev 1.0
// ============================================================================
package image_write_pkg;

   localparam int CFG_IW_IMG_W  = 12;
   localparam int CFG_IW_IMG_DH = 13;
   localparam int CFG_IW_START  = 14;
   localparam int IW_CNT_W      = 16;

   typedef enum logic [1:0] {
      IW_IDLE   = 2'd0,
      IW_ACTIVE = 2'd1,
      IW_DONE   = 2'd2
   } iw_state_e;

endpackage
`default_nettype wire

// File: rtl/image_write_cnt.sv
`default_nettype none
// ============================================================================
// image_write_cnt : w/h/d nested wrap counter, w fastest; flags the last beat
// Rev 1.0
// ============================================================================
module image_write_cnt
   import image_write_pkg::*;
#(
   parameter int CW = IW_CNT_W
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          clr_i,
   input  logic          adv_i,
   input  logic [CW-1:0] w_max_i,
   input  logic [CW-1:0] h_max_i,
   input  logic [CW-1:0] d_max_i,
   output logic          last_o
);

   logic [CW-1:0] w_q, h_q, d_q;
   logic [CW-1:0] w_d, h_d, d_d;
   logic          w_end, h_end, d_end;

   assign w_end  = (w_q == w_max_i);
   assign h_end  = (h_q == h_max_i);
   assign d_end  = (d_q == d_max_i);
   assign last_o = w_end & h_end & d_end;

   always_comb begin
      w_d = w_q;
      h_d = h_q;
      d_d = d_q;
      if (clr_i) begin
         w_d = '0;
         h_d = '0;
         d_d = '0;
      end else if (adv_i) begin
         if (w_end) begin
            w_d = '0;
            if (h_end) begin
               h_d = '0;
               d_d = d_end ? '0 : d_q + CW'(1);
            end else begin
               h_d = h_q + CW'(1);
            end
         end else begin
            w_d = w_q + CW'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         w_q <= '0;
         h_q <= '0;
         d_q <= '0;
      end else begin
         w_q <= w_d;
         h_q <= h_d;
         d_q <= d_d;
      end
   end

endmodule
`default_nettype wire

// File: rtl/image_write.sv
`default_nettype none
// ============================================================================
// image_write : writes the processed pixel-group stream to linear image memory
// Rev 1.0
// ============================================================================
module image_write
   import image_write_pkg::*;
#(
   parameter int CFG_DWIDTH = 32,
   parameter int CFG_AWIDTH = 5,
   parameter int GROUP_NB   = 4,
   parameter int IMG_WIDTH  = 16,
   parameter int MEM_AWIDTH = 16
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic [CFG_DWIDTH-1:0]         cfg_data_i,
   input  logic [CFG_AWIDTH-1:0]         cfg_addr_i,
   input  logic                          cfg_valid_i,
   input  logic                          next_i,
   output logic                          next_rdy_o,
   input  logic [GROUP_NB*IMG_WIDTH-1:0] result_bus_i,
   input  logic                          result_last_i,
   input  logic                          result_val_i,
   output logic                          result_rdy_o,
   output logic                          wr_val_o,
   output logic [MEM_AWIDTH-1:0]         wr_addr_o,
   output logic [GROUP_NB*IMG_WIDTH-1:0] wr_data_o,
   output logic                          done_o,
   output logic                          last_err_o
);

   iw_state_e                     state_q;
   logic [IW_CNT_W-1:0]           cfg_w_q, cfg_h_q, cfg_d_q;
   logic [IW_CNT_W-1:0]           sh_w_q, sh_h_q, sh_d_q;
   logic [MEM_AWIDTH-1:0]         cfg_start_q, addr_q;
   logic                          next_rdy_q, result_rdy_q, wr_val_q, done_q, last_err_q;
   logic [MEM_AWIDTH-1:0]         wr_addr_q;
   logic [GROUP_NB*IMG_WIDTH-1:0] wr_data_q;
   logic                          start_d, accept_d, beat_last_d;

   assign start_d  = (state_q == IW_IDLE) & next_i & next_rdy_q;
   assign accept_d = (state_q == IW_ACTIVE) & result_val_i & result_rdy_q;

   image_write_cnt #(.CW(IW_CNT_W)) u_cnt (
      .clk     (clk),
      .rst_n   (rst_n),
      .clr_i   (start_d),
      .adv_i   (accept_d),
      .w_max_i (sh_w_q),
      .h_max_i (sh_h_q),
      .d_max_i (sh_d_q),
      .last_o  (beat_last_d)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IW_IDLE;
         cfg_w_q      <= '0;
         cfg_h_q      <= '0;
         cfg_d_q      <= '0;
         cfg_start_q  <= '0;
         sh_w_q       <= '0;
         sh_h_q       <= '0;
         sh_d_q       <= '0;
         addr_q       <= '0;
         next_rdy_q   <= 1'b1;
         result_rdy_q <= 1'b0;
         wr_val_q     <= 1'b0;
         wr_addr_q    <= '0;
         wr_data_q    <= '0;
         done_q       <= 1'b0;
         last_err_q   <= 1'b0;
      end else begin
         wr_val_q <= 1'b0;
         done_q   <= 1'b0;
         // Live registers may change at any time; the running image uses the shadows.
         if (cfg_valid_i) begin
            if (cfg_addr_i == CFG_AWIDTH'(CFG_IW_IMG_W)) begin
               cfg_w_q <= cfg_data_i[15:0];
            end else if (cfg_addr_i == CFG_AWIDTH'(CFG_IW_IMG_DH)) begin
               cfg_h_q <= cfg_data_i[15:0];
               cfg_d_q <= cfg_data_i[31:16];
            end else if (cfg_addr_i == CFG_AWIDTH'(CFG_IW_START)) begin
               cfg_start_q <= cfg_data_i[MEM_AWIDTH-1:0];
            end
         end
         unique case (state_q)
            IW_IDLE: begin
               if (start_d) begin
                  sh_w_q       <= cfg_w_q;
                  sh_h_q       <= cfg_h_q;
                  sh_d_q       <= cfg_d_q;
                  addr_q       <= cfg_start_q;
                  last_err_q   <= 1'b0;
                  next_rdy_q   <= 1'b0;
                  result_rdy_q <= 1'b1;
                  state_q      <= IW_ACTIVE;
               end
            end
            IW_ACTIVE: begin
               if (accept_d) begin
                  wr_val_q  <= 1'b1;
                  wr_addr_q <= addr_q;
                  wr_data_q <= result_bus_i;
                  addr_q    <= addr_q + MEM_AWIDTH'(1);
                  // The counters decide the end of image; result_last is only checked.
                  if (result_last_i != beat_last_d) begin
                     last_err_q <= 1'b1;
                  end
                  if (beat_last_d) begin
                     result_rdy_q <= 1'b0;
                     state_q      <= IW_DONE;
                  end
               end
            end
            IW_DONE: begin
               done_q     <= 1'b1;
               next_rdy_q <= 1'b1;
               state_q    <= IW_IDLE;
            end
            default: begin
               state_q <= IW_IDLE;
            end
         endcase
      end
   end

   assign next_rdy_o   = next_rdy_q;
   assign result_rdy_o = result_rdy_q;
   assign wr_val_o     = wr_val_q;
   assign wr_addr_o    = wr_addr_q;
   assign wr_data_o    = wr_data_q;
   assign done_o       = done_q;
   assign last_err_o   = last_err_q;

endmodule
`default_nettype wire

// File: tb/tb_image_write.sv
`default_nettype none
// ============================================================================
// tb_image_write : directed sequence with random data/bubbles vs a beat-level model
// Rev 1.0
// ============================================================================
module tb_image_write;

   localparam int DW = 64;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic [31:0]   drv_cfg_data = '0;
   logic [4:0]    drv_cfg_addr = '0;
   logic          drv_cfg_valid = 1'b0;
   logic          drv_next = 1'b0;
   logic [DW-1:0] drv_data = '0;
   logic          drv_last = 1'b0;
   logic          drv_val = 1'b0;
   logic          next_rdy, result_rdy, wr_val, done, last_err;
   logic [15:0]   wr_addr;
   logic [DW-1:0] wr_data;

   always #5 clk = ~clk;

   image_write #(
      .CFG_DWIDTH (32),
      .CFG_AWIDTH (5),
      .GROUP_NB   (4),
      .IMG_WIDTH  (16),
      .MEM_AWIDTH (16)
   ) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .cfg_data_i    (drv_cfg_data),
      .cfg_addr_i    (drv_cfg_addr),
      .cfg_valid_i   (drv_cfg_valid),
      .next_i        (drv_next),
      .next_rdy_o    (next_rdy),
      .result_bus_i  (drv_data),
      .result_last_i (drv_last),
      .result_val_i  (drv_val),
      .result_rdy_o  (result_rdy),
      .wr_val_o      (wr_val),
      .wr_addr_o     (wr_addr),
      .wr_data_o     (wr_data),
      .done_o        (done),
      .last_err_o    (last_err)
   );

   // Reference: an image is total = W*H*D beats written at base + beat index.
   int unsigned m_w, m_h, m_d, m_start, m_base;
   int          m_phase;   // 0 idle, 1 accepting beats, 2 finishing
   longint      m_total, m_cnt;
   bit          m_err;
   bit          e_wr_val, e_done;
   logic [15:0] e_addr;
   logic [DW-1:0] e_data;
   int          n_chk = 0, n_pass = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
   endtask

   task automatic model_reset();
      m_w = 0; m_h = 0; m_d = 0; m_start = 0; m_base = 0;
      m_phase = 0; m_total = 0; m_cnt = 0; m_err = 1'b0;
   endtask

   task automatic reset_checks();
      chk("rst_next_rdy", 64'(next_rdy), 64'd1);
      chk("rst_result_rdy", 64'(result_rdy), 64'd0);
      chk("rst_wr_val", 64'(wr_val), 64'd0);
      chk("rst_wr_addr", 64'(wr_addr), 64'd0);
      chk("rst_wr_data", 64'(wr_data), 64'd0);
      chk("rst_done", 64'(done), 64'd0);
      chk("rst_last_err", 64'(last_err), 64'd0);
   endtask

   task automatic tick();
      e_wr_val = 1'b0;
      e_done   = 1'b0;
      case (m_phase)
         0: if (drv_next) begin
               m_base  = m_start;
               m_total = longint'(m_w + 1) * longint'(m_h + 1) * longint'(m_d + 1);
               m_cnt   = 0;
               m_err   = 1'b0;
               m_phase = 1;
            end
         1: if (drv_val) begin
               e_wr_val = 1'b1;
               e_addr   = 16'(longint'(m_base) + m_cnt);
               e_data   = drv_data;
               if (drv_last != (m_cnt == m_total - 1)) m_err = 1'b1;
               m_cnt++;
               if (m_cnt == m_total) m_phase = 2;
            end
         default: begin
            e_done  = 1'b1;
            m_phase = 0;
         end
      endcase
      if (drv_cfg_valid) begin
         case (drv_cfg_addr)
            5'd12: m_w = int'(drv_cfg_data[15:0]);
            5'd13: begin
               m_h = int'(drv_cfg_data[15:0]);
               m_d = int'(drv_cfg_data[31:16]);
            end
            5'd14: m_start = int'(drv_cfg_data[15:0]);
            default: ;
         endcase
      end
      @(posedge clk);
      #1;
      drv_next      = 1'b0;
      drv_cfg_valid = 1'b0;
      chk("next_rdy", 64'(next_rdy), 64'(m_phase == 0));
      chk("result_rdy", 64'(result_rdy), 64'(m_phase == 1));
      chk("wr_val", 64'(wr_val), 64'(e_wr_val));
      chk("done", 64'(done), 64'(e_done));
      chk("last_err", 64'(last_err), 64'(m_err));
      if (e_wr_val) begin
         chk("wr_addr", 64'(wr_addr), 64'(e_addr));
         chk("wr_data", 64'(wr_data), 64'(e_data));
      end
   endtask

   task automatic cfg_write(input logic [4:0] a, input logic [31:0] d);
      drv_val       = 1'b0;
      drv_last      = 1'b0;
      drv_cfg_addr  = a;
      drv_cfg_data  = d;
      drv_cfg_valid = 1'b1;
      tick();
   endtask

   task automatic start_image();
      drv_val  = 1'b0;
      drv_last = 1'b0;
      drv_next = 1'b1;
      tick();
   endtask

   task automatic drive_beat(input bit bubbles, input longint early);
      drv_val  = bubbles ? 1'($urandom_range(0, 1)) : 1'b1;
      drv_data = {$urandom, $urandom};
      drv_last = drv_val && ((early >= 0) ? (m_cnt == early) : (m_cnt == m_total - 1));
      tick();
   endtask

   task automatic run_beats(input int n);
      for (int i = 0; i < n; i++) drive_beat(1'b0, -1);
   endtask

   task automatic run_image(input bit bubbles, input longint early);
      int guard;
      guard = 0;
      while (m_phase != 0 && guard < 3000) begin
         drive_beat(bubbles, early);
         guard++;
      end
      if (guard >= 3000) chk("image_timeout", 64'd1, 64'd0);
      drv_val  = 1'b0;
      drv_last = 1'b0;
      tick();
   endtask

   task automatic cfg_basic();
      cfg_write(5'd12, 32'd9);
      cfg_write(5'd13, {16'd1, 16'd4});
      cfg_write(5'd14, 32'h100);
   endtask

   initial begin
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      reset_checks();
      @(negedge clk);
      rst_n = 1'b1;

      // Basic 10x5x2 image at 0x100, continuous beats.
      cfg_basic();
      start_image();
      run_image(1'b0, -1);

      // Same image with random bubbles.
      start_image();
      run_image(1'b1, -1);

      // result_last on beat 50: error flagged, image still runs to the count.
      start_image();
      run_image(1'b0, 49);

      // Config change and next mid-image only affect the following image.
      start_image();
      run_beats(20);
      cfg_write(5'd14, 32'h200);
      start_image();
      run_image(1'b0, -1);
      start_image();
      run_image(1'b1, -1);

      // Asynchronous reset mid-image.
      cfg_write(5'd14, 32'h100);
      start_image();
      run_beats(30);
      rst_n = 1'b0;
      #1;
      reset_checks();
      model_reset();
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      cfg_basic();
      start_image();
      run_image(1'b0, -1);

      // Degenerate 1x1x1 at the top of memory, then a 2-beat wrap.
      cfg_write(5'd12, 32'd0);
      cfg_write(5'd13, 32'd0);
      cfg_write(5'd14, 32'hFFFF);
      start_image();
      run_image(1'b0, -1);
      cfg_write(5'd12, 32'd1);
      start_image();
      run_image(1'b1, -1);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
`default_nettype wire
